// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO controller.
//   DATA_WIDTH_DEF : default width of one stored word
//   ADDR_WIDTH_DEF : default log2 of the FIFO depth
//   DEPTH_DEF      : default number of storage words
package sync_fifo_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

endpackage : sync_fifo_ctrl_pkg

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bundle of the synchronous FIFO.
//   wr_en, wr_data      : write request and word (producer -> FIFO)
//   rd_en               : read request (consumer -> FIFO)
//   rd_data             : registered read word (FIFO -> consumer)
//   full, empty, count  : registered occupancy status
//   overflow, underflow : one-cycle error pulses for rejected requests
// master = the side driving requests (producer/consumer), slave = the FIFO.
interface sync_fifo_ctrl_if
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, count, overflow, underflow
    );

endinterface : sync_fifo_ctrl_if

// File: rtl/sync_fifo_ctrl_ptr_counter.sv
// fifo_ptr_counter: enable-driven up-counter used for the FIFO pointers.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset, clears the count
//   enable    : increment by one on the next edge
//   count_out : current count, wraps modulo 2**W
module fifo_ptr_counter #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] count_out
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count_out = count_reg;

endmodule : fifo_ptr_counter

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with register-array storage.
//   clock : rising-edge clock for all state
//   reset : asynchronous active-low reset (contents discarded, flags cleared)
//   bus   : slave side of sync_fifo_ctrl_if (requests in, data/status out)
// Pointers carry one extra wrap bit so full and empty can be told apart
// when the address bits match. All status outputs are registered and
// updated on the same edge as the pointers they are derived from.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    sync_fifo_ctrl_if.slave    bus
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_acc;
    logic                  rd_acc;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr_next;
    logic [PW-1:0]         rd_ptr_next;
    logic [PW-1:0]         ptr_match;

    logic                  full_reg;
    logic                  full_next;
    logic                  empty_reg;
    logic                  empty_next;
    logic [PW-1:0]         count_reg;
    logic [PW-1:0]         count_next;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Accepts use the flags as registered before the edge, so a request
    // seen while full/empty is rejected even if the other side frees or
    // fills a slot on that same edge (no fall-through).
    assign wr_acc = bus.wr_en & ~full_reg;
    assign rd_acc = bus.rd_en & ~empty_reg;

    fifo_ptr_counter #(.W(PW)) u_wr_ptr (
        .clock     (clock),
        .reset     (reset),
        .enable    (wr_acc),
        .count_out (wr_ptr)
    );

    fifo_ptr_counter #(.W(PW)) u_rd_ptr (
        .clock     (clock),
        .reset     (reset),
        .enable    (rd_acc),
        .count_out (rd_ptr)
    );

    // Flags are computed from the pointer values the counters will hold
    // after this edge, so the registered flags stay in step with them.
    always_comb begin
        wr_ptr_next = wr_ptr + PW'(wr_acc);
        rd_ptr_next = rd_ptr + PW'(rd_acc);
    end

    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_ptr_match
            assign ptr_match[gi] = (wr_ptr_next[gi] == rd_ptr_next[gi]);
        end
    endgenerate

    always_comb begin
        count_next = wr_ptr_next - rd_ptr_next;
        empty_next = &ptr_match;
        // Same slot but opposite lap: writer is a full lap ahead.
        full_next  = ~ptr_match[PW-1] & (&ptr_match[PW-2:0]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            rd_data_reg   <= '0;
        end else begin
            full_reg      <= full_next;
            empty_reg     <= empty_next;
            count_reg     <= count_next;
            overflow_reg  <= bus.wr_en & full_reg;
            underflow_reg <= bus.rd_en & empty_reg;
            if (rd_acc) begin
                rd_data_reg <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Storage has no reset; after a reset the pointers are equal, so any
    // stale word is unreachable until it has been overwritten.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data   = rd_data_reg;
    assign bus.full      = full_reg;
    assign bus.empty     = empty_reg;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;

endmodule : sync_fifo_ctrl

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] q[$];

    always #5 clock = ~clock;

    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = 8'h00;
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        bus.wr_en = 1'b1; bus.wr_data = 8'h5C; step();
        bus.wr_en = 1'b0; bus.rd_en = 1'b1; step();
        bus.rd_en = 1'b0; bus.wr_en = 1'b1; bus.wr_data = 8'h33; step();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.rd_data !== 8'h5C) begin errors++; $display("FAIL pre_reset_rd_data: got %h expected 5c", bus.rd_data); end
        checks++;
        if (bus.count !== 5'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", bus.count); end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        checks++;
        if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++;
        if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++;
        if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got ovf=%b unf=%b expected 0 0", bus.overflow, bus.underflow);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            step();
            $display("write %h count=%0d", 8'(i), bus.count);
        end
        bus.wr_en = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
            errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1 16", bus.full, bus.count);
        end
        bus.wr_en = 1'b1; bus.wr_data = 8'hAA;
        step();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
            errors++; $display("FAIL overflow_pulse: got ovf=%b count=%0d expected 1 16", bus.overflow, bus.count);
        end
        step();
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle: got %b expected 0", bus.overflow); end
        $display("test_fill_overflow: done");
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 16; i++) begin
            bus.rd_en = 1'b1;
            step();
            $display("read %h", bus.rd_data);
            checks++;
            if (bus.rd_data !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, bus.rd_data, 8'(i)); end
        end
        bus.rd_en = 1'b0;
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            errors++; $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", bus.empty, bus.count);
        end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.underflow !== 1'b1 || bus.rd_data !== 8'h0F) begin
            errors++; $display("FAIL underflow_pulse: got unf=%b rd=%h expected 1 0f", bus.underflow, bus.rd_data);
        end
        step();
        checks++;
        if (bus.underflow !== 1'b0 || bus.rd_data !== 8'h0F) begin
            errors++; $display("FAIL underflow_one_cycle: got unf=%b rd=%h expected 0 0f", bus.underflow, bus.rd_data);
        end
        $display("test_drain_underflow: done");
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h10 + 8'(i); step();
        end
        for (int k = 0; k < 20; k++) begin
            bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'h20 + 8'(k);
            step();
            exp = (k < 8) ? 8'h10 + 8'(k) : 8'h20 + 8'(k - 8);
            $display("wr+rd write %h read %h count=%0d", 8'h20 + 8'(k), bus.rd_data, bus.count);
            checks++;
            if (bus.count !== 5'd8 || bus.rd_data !== exp) begin
                errors++; $display("FAIL both_steady[%0d]: got count=%0d rd=%h expected 8 %h", k, bus.count, bus.rd_data, exp);
            end
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rd_en = 1'b1; step();
            exp = 8'h2C + 8'(i);
            checks++;
            if (bus.rd_data !== exp) begin errors++; $display("FAIL both_drain[%0d]: got %h expected %h", i, bus.rd_data, exp); end
        end
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'h77;
        step();
        checks++;
        if (bus.count !== 5'd1 || bus.underflow !== 1'b1 || bus.rd_data !== 8'h33) begin
            errors++; $display("FAIL both_when_empty: got count=%0d unf=%b rd=%h expected 1 1 33", bus.count, bus.underflow, bus.rd_data);
        end
        bus.rd_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.wr_data = 8'h80 + 8'(i); step();
        end
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
            errors++; $display("FAIL refill_full: got full=%b count=%0d expected 1 16", bus.full, bus.count);
        end
        bus.rd_en = 1'b1; bus.wr_data = 8'h99;
        step();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.count !== 5'd15 || bus.overflow !== 1'b1 || bus.rd_data !== 8'h77) begin
            errors++; $display("FAIL both_when_full: got count=%0d ovf=%b rd=%h expected 15 1 77", bus.count, bus.overflow, bus.rd_data);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            exp = 8'h80 + 8'(i);
            checks++;
            if (bus.rd_data !== exp) begin errors++; $display("FAIL full_drain[%0d]: got %h expected %h", i, bus.rd_data, exp); end
        end
        bus.rd_en = 1'b0;
        step();
        checks++;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL simul_end_empty: got %b expected 1", bus.empty); end
        $display("test_simultaneous: done");
    endtask

    task automatic test_wrap();
        logic       wr, rd, m_full, m_empty;
        logic [7:0] d;
        logic [7:0] exp_rd;
        logic [16:0] got, exp;
        exp_rd = 8'h8E;
        for (int c = 0; c < 100; c++) begin
            if (c < 50) begin
                wr = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 3) == 0);
            end else begin
                wr = ($urandom_range(0, 3) == 0); rd = ($urandom_range(0, 3) != 0);
            end
            d       = 8'($urandom_range(0, 255));
            m_full  = (q.size() == 16);
            m_empty = (q.size() == 0);
            if (rd && !m_empty) exp_rd = q.pop_front();
            if (wr && !m_full) q.push_back(d);
            bus.wr_en = wr; bus.rd_en = rd; bus.wr_data = d;
            step();
            exp = {5'(q.size()), (q.size() == 16), (q.size() == 0), wr & m_full, rd & m_empty, exp_rd};
            got = {bus.count, bus.full, bus.empty, bus.overflow, bus.underflow, bus.rd_data};
            $display("rand %0d wr=%b rd=%b data=%h count=%0d rd_data=%h", c, wr, rd, d, bus.count, bus.rd_data);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL wrap_cycle[%0d]: got %h expected %h", c, got, exp); end
        end
        bus.wr_en = 1'b0;
        while (q.size() > 0) begin
            bus.rd_en = 1'b1;
            exp_rd = q.pop_front();
            step();
            checks++;
            if (bus.rd_data !== exp_rd) begin errors++; $display("FAIL wrap_drain: got %h expected %h", bus.rd_data, exp_rd); end
        end
        bus.rd_en = 1'b0;
        step();
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            errors++; $display("FAIL wrap_end_empty: got empty=%b count=%0d expected 1 0", bus.empty, bus.count);
        end
        $display("test_wrap: done");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h40 + 8'(i); step();
        end
        checks++;
        if (bus.count !== 5'd5) begin errors++; $display("FAIL mid_fill_count: got %0d expected 5", bus.count); end
        bus.wr_data = 8'h45;
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.full !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags: got empty=%b count=%0d full=%b expected 1 0 0", bus.empty, bus.count, bus.full);
        end
        @(posedge clock); #1;
        reset = 1'b1; bus.wr_en = 1'b0;
        step();
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            errors++; $display("FAIL mid_release_empty: got empty=%b count=%0d expected 1 0", bus.empty, bus.count);
        end
        bus.wr_en = 1'b1; bus.wr_data = 8'hC1; step();
        bus.wr_data = 8'hC2; step();
        bus.wr_en = 1'b0; bus.rd_en = 1'b1; step();
        checks++;
        if (bus.rd_data !== 8'hC1) begin errors++; $display("FAIL mid_first_read: got %h expected c1", bus.rd_data); end
        step();
        checks++;
        if (bus.rd_data !== 8'hC2) begin errors++; $display("FAIL mid_second_read: got %h expected c2", bus.rd_data); end
        step();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.empty !== 1'b1 || bus.underflow !== 1'b1 || bus.rd_data !== 8'hC2) begin
            errors++; $display("FAIL mid_third_read: got empty=%b unf=%b rd=%h expected 1 1 c2", bus.empty, bus.underflow, bus.rd_data);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_sync_fifo_ctrl
